queue_counter: RTL and testbench



---
 rtl/queue_counter.sv | 148 ++++++++++++++
 tb/tb_queue_counter.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/queue_counter.sv
// queue_counter: debounced arrival/departure sensors feeding a saturating 0..7 person count plus registered teller count.
// Define QUEUE_ERR_EN to build the sticky err flag for rejected arrivals/departures; otherwise err is tied low.
module queue_counter_debounce #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic ev
);
    typedef enum logic [1:0] {LOW, CONF_HIGH, HIGH, CONF_LOW} state_t;
    localparam logic [4:0] DC = 5'(DEBOUNCE_CYCLES);
    state_t state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [3:0] cnt_q, cnt_d;
    logic ev_q, ev_d, s, done;
    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], din};
        s       = sync_q[SYNC_STAGES-1];
        // the sample taken on this edge would be the DEBOUNCE_CYCLES-th stable one
        done    = ({1'b0, cnt_q} + 5'd1) >= DC;
        state_d = state_q;
        cnt_d   = cnt_q;
        ev_d    = 1'b0;
        case (state_q)
            LOW: if (s) begin
                state_d = CONF_HIGH;
                cnt_d   = 4'd1;
            end
            CONF_HIGH: if (!s) begin
                state_d = LOW;
                cnt_d   = '0;
            end else if (done) begin
                state_d = HIGH;
                cnt_d   = '0;
                ev_d    = 1'b1;
            end else cnt_d = cnt_q + 4'd1;
            HIGH: if (!s) begin
                state_d = CONF_LOW;
                cnt_d   = 4'd1;
            end
            default: if (s) begin
                state_d = HIGH;
                cnt_d   = '0;
            end else if (done) begin
                state_d = LOW;
                cnt_d   = '0;
            end else cnt_d = cnt_q + 4'd1;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= LOW;
            sync_q  <= '0;
            cnt_q   <= '0;
            ev_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            ev_q    <= ev_d;
        end
    end
    assign ev = ev_q;
endmodule

module queue_counter #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sensorBack,
    input  logic       sensorFront,
    input  logic [1:0] tellerSel,
    output logic [2:0] pCount,
    output logic [1:0] tCount,
    output logic       full,
    output logic       empty,
    output logic       update,
    output logic       err
);
    logic arr, dep;
    logic [1:0] ts1_q, ts1_d, ts2_q, ts2_d, t_q, t_d;
    logic [2:0] p_q, p_d;
    logic full_q, full_d, empty_q, empty_d, chg_q, chg_d, upd_q, upd_d;

    queue_counter_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_back (
        .clk(clk), .rst(rst), .din(sensorBack), .ev(arr)
    );
    queue_counter_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_front (
        .clk(clk), .rst(rst), .din(sensorFront), .ev(dep)
    );

    always_comb begin
        ts1_d   = tellerSel;
        ts2_d   = ts1_q;
        t_d     = (ts2_q != 2'd0) ? ts2_q : t_q;
        // simultaneous arrival and departure cancel out
        p_d     = (arr && !dep && p_q != 3'd7) ? p_q + 3'd1 :
                  (dep && !arr && p_q != 3'd0) ? p_q - 3'd1 : p_q;
        full_d  = p_d == 3'd7;
        empty_d = p_d == 3'd0;
        chg_d   = (p_d != p_q) || (t_d != t_q);
        upd_d   = chg_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ts1_q   <= '0;
            ts2_q   <= '0;
            t_q     <= 2'd1;
            p_q     <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            chg_q   <= 1'b0;
            upd_q   <= 1'b0;
        end else begin
            ts1_q   <= ts1_d;
            ts2_q   <= ts2_d;
            t_q     <= t_d;
            p_q     <= p_d;
            full_q  <= full_d;
            empty_q <= empty_d;
            chg_q   <= chg_d;
            upd_q   <= upd_d;
        end
    end

`ifdef QUEUE_ERR_EN
    logic err_q, err_d;
    always_comb err_d = err_q || ((arr ^ dep) && (arr ? p_q == 3'd7 : p_q == 3'd0));
    always_ff @(posedge clk or posedge rst) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= err_d;
    end
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign pCount = p_q;
    assign tCount = t_q;
    assign full   = full_q;
    assign empty  = empty_q;
    assign update = upd_q;
endmodule

// File: tb/tb_queue_counter.sv
// tb_queue_counter: directed scenarios for queue_counter at default parameters (7-edge sensor latency, 3-edge teller latency).
module tb_queue_counter;
    logic clk = 1'b0, rst = 1'b1, sensorBack = 1'b0, sensorFront = 1'b0;
    logic [1:0] tellerSel = 2'd1;
    logic [2:0] pCount;
    logic [1:0] tCount;
    logic full, empty, update, err;
    int pass_cnt = 0, total_cnt = 0;
`ifdef QUEUE_ERR_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    queue_counter dut (
        .clk(clk), .rst(rst), .sensorBack(sensorBack), .sensorFront(sensorFront),
        .tellerSel(tellerSel), .pCount(pCount), .tCount(tCount), .full(full),
        .empty(empty), .update(update), .err(err)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // drive both sensors for one clean pulse, counting update pulses seen
    task automatic pulse(input logic b, input logic f, output int ups);
        ups = 0;
        sensorBack  = b;
        sensorFront = f;
        for (int i = 0; i < 10; i++) begin tick(1); ups += int'(update); end
        sensorBack  = 1'b0;
        sensorFront = 1'b0;
        for (int i = 0; i < 12; i++) begin tick(1); ups += int'(update); end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(1);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(3);
        total_cnt++; if ({pCount, tCount, empty, full, update, err} !== {3'd0, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0}) $display("FAIL reset_outputs got p=%0d t=%0d e=%b f=%b u=%b err=%b", pCount, tCount, empty, full, update, err); else pass_cnt++;
        rst = 1'b0;
        tick(1);
    endtask

    task automatic test_arrival();
        sensorBack = 1'b1;
        tick(6);
        total_cnt++; if ({pCount, empty} !== {3'd0, 1'b1}) $display("FAIL arr_edge6 got p=%0d e=%b want p=0 e=1", pCount, empty); else pass_cnt++;
        tick(1);
        total_cnt++; if ({pCount, empty, update} !== {3'd1, 1'b0, 1'b0}) $display("FAIL arr_edge7 got p=%0d e=%b u=%b want p=1 e=0 u=0", pCount, empty, update); else pass_cnt++;
        tick(1);
        total_cnt++; if (update !== 1'b1) $display("FAIL arr_update_edge8 got %b want 1", update); else pass_cnt++;
        tick(1);
        total_cnt++; if (update !== 1'b0) $display("FAIL arr_update_edge9 got %b want 0", update); else pass_cnt++;
        tick(1);
        sensorBack = 1'b0;
        tick(12);
    endtask

    task automatic test_departure_empty();
        int ups;
        pulse(1'b0, 1'b1, ups);
        total_cnt++; if ({pCount, empty, ups} !== {3'd0, 1'b1, 32'd1}) $display("FAIL dep_to_zero got p=%0d e=%b ups=%0d want 0 1 1", pCount, empty, ups); else pass_cnt++;
        pulse(1'b0, 1'b1, ups);
        total_cnt++; if ({pCount, ups} !== {3'd0, 32'd0}) $display("FAIL dep_at_zero got p=%0d ups=%0d want 0 0", pCount, ups); else pass_cnt++;
        total_cnt++; if (err !== ERR_EXP) $display("FAIL dep_at_zero_err got %b want %b", err, ERR_EXP); else pass_cnt++;
    endtask

    task automatic test_saturate();
        int ups;
        sensorBack = 1'b1;
        tick(3);
        sensorBack = 1'b0;
        tick(12);
        total_cnt++; if (pCount !== 3'd0) $display("FAIL glitch got p=%0d want 0", pCount); else pass_cnt++;
        do_reset();
        for (int i = 1; i <= 8; i++) begin
            pulse(1'b1, 1'b0, ups);
            if (i == 6) begin
                total_cnt++; if ({pCount, full} !== {3'd6, 1'b0}) $display("FAIL sat_six got p=%0d f=%b want 6 0", pCount, full); else pass_cnt++;
            end
            if (i == 7) begin
                total_cnt++; if ({pCount, full, err} !== {3'd7, 1'b1, 1'b0}) $display("FAIL sat_seven got p=%0d f=%b err=%b want 7 1 0", pCount, full, err); else pass_cnt++;
            end
        end
        total_cnt++; if ({pCount, full, ups} !== {3'd7, 1'b1, 32'd0}) $display("FAIL sat_eighth got p=%0d f=%b ups=%0d want 7 1 0", pCount, full, ups); else pass_cnt++;
        total_cnt++; if (err !== ERR_EXP) $display("FAIL sat_err got %b want %b", err, ERR_EXP); else pass_cnt++;
    endtask

    task automatic test_simultaneous();
        int ups;
        do_reset();
        for (int i = 0; i < 3; i++) pulse(1'b1, 1'b0, ups);
        total_cnt++; if (pCount !== 3'd3) $display("FAIL sim_setup got p=%0d want 3", pCount); else pass_cnt++;
        pulse(1'b1, 1'b1, ups);
        total_cnt++; if ({pCount, ups, err} !== {3'd3, 32'd0, 1'b0}) $display("FAIL simultaneous got p=%0d ups=%0d err=%b want 3 0 0", pCount, ups, err); else pass_cnt++;
    endtask

    task automatic test_teller();
        int ups;
        tellerSel = 2'd2;
        tick(2);
        total_cnt++; if (tCount !== 2'd1) $display("FAIL tel2_edge2 got %0d want 1", tCount); else pass_cnt++;
        tick(1);
        total_cnt++; if ({tCount, update} !== {2'd2, 1'b0}) $display("FAIL tel2_edge3 got t=%0d u=%b want 2 0", tCount, update); else pass_cnt++;
        tick(1);
        total_cnt++; if (update !== 1'b1) $display("FAIL tel2_update got %b want 1", update); else pass_cnt++;
        tick(2);
        tellerSel = 2'd0;
        ups = 0;
        for (int i = 0; i < 6; i++) begin tick(1); ups += int'(update); end
        total_cnt++; if ({tCount, ups} !== {2'd2, 32'd0}) $display("FAIL tel0_hold got t=%0d ups=%0d want 2 0", tCount, ups); else pass_cnt++;
        tellerSel = 2'd3;
        tick(2);
        total_cnt++; if (tCount !== 2'd2) $display("FAIL tel3_edge2 got %0d want 2", tCount); else pass_cnt++;
        tick(1);
        total_cnt++; if (tCount !== 2'd3) $display("FAIL tel3_edge3 got %0d want 3", tCount); else pass_cnt++;
        tick(1);
        total_cnt++; if (update !== 1'b1) $display("FAIL tel3_update got %b want 1", update); else pass_cnt++;
        tick(2);
    endtask

    task automatic test_reset_mid_debounce();
        int ups;
        for (int i = 0; i < 2; i++) pulse(1'b1, 1'b0, ups);
        total_cnt++; if (pCount !== 3'd5) $display("FAIL mid_setup got p=%0d want 5", pCount); else pass_cnt++;
        sensorBack = 1'b1;
        tick(4);
        #2 rst = 1'b1;
        #1;
        total_cnt++; if ({pCount, tCount, empty, full, update} !== {3'd0, 2'd1, 1'b1, 1'b0, 1'b0}) $display("FAIL mid_async_reset got p=%0d t=%0d e=%b f=%b u=%b", pCount, tCount, empty, full, update); else pass_cnt++;
        tick(3);
        rst = 1'b0;
        tick(5);
        total_cnt++; if (pCount !== 3'd0) $display("FAIL mid_edge5 got p=%0d want 0", pCount); else pass_cnt++;
        tick(2);
        total_cnt++; if ({pCount, empty} !== {3'd1, 1'b0}) $display("FAIL mid_edge7 got p=%0d e=%b want 1 0", pCount, empty); else pass_cnt++;
        sensorBack = 1'b0;
        tick(12);
    endtask

    initial begin
        test_reset();
        test_arrival();
        test_departure_empty();
        test_saturate();
        test_simultaneous();
        test_teller();
        test_reset_mid_debounce();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
